// File: rtl/tt_um_dice_roller_if.sv
// rtl/tt_um_dice_roller_if.sv - TinyTapeout tile pin bundle for the dice roller
//
// Groups the tile's user pins so the die core and its driver share one port.
// Ports:
//   ena      tile enable (carried for completeness, not used by the core)
//   ui_in    [6:0] die buttons d4..d100, [7] unused
//   uio_in   [5] button level, [6] segment lit level, [7] common active level
//   uo_out   segments a..g in [6:0], dp in [7]
//   uio_out  [0] units common, [1] tens common, [7:2] zero
//   uio_oe   output enables for uio_out
// Modports: master drives the inputs (board / bench), slave is the die core.

interface tt_um_dice_roller_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    output ena, ui_in, uio_in,
    input  uo_out, uio_out, uio_oe
  );

  modport slave (
    input  ena, ui_in, uio_in,
    output uo_out, uio_out, uio_oe
  );
endinterface

// File: rtl/tt_um_dice_roller.sv
// rtl/tt_um_dice_roller.sv - seven-die electronic dice with two-digit muxed 7-segment display
//
// Holding a die button cycles a counter through 1..N at clock rate; releasing it
// freezes the value, which is shown on a multiplexed two-digit display.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    tt_um_dice_roller_if.slave (ui_in buttons, uio_in polarity straps,
//          uo_out segments, uio_out digit commons, uio_oe enables)
// Parameters:
//   MUX_BITS     display digit toggles every 2^MUX_BITS clocks
//   SYNC_STAGES  synchronizer depth on every button input
// Optional feature macro: ROLLING_DISPLAY_EN -- when defined the live counter is
// shown while rolling; otherwise the display is blank during a roll.

module tt_um_dice_roller #(
  parameter int MUX_BITS    = 10,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  tt_um_dice_roller_if.slave    bus
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_ROLL = 1'b1;

  // Straps
  logic btn_level, seg_level, com_level;
  assign btn_level = bus.uio_in[5];
  assign seg_level = bus.uio_in[6];
  assign com_level = bus.uio_in[7];

  logic unused_pins;
  assign unused_pins = &{1'b0, bus.ena, bus.ui_in[7], bus.uio_in[4:0]};

  // Button synchronizer; a stage value of 1 always means "pressed"
  logic [6:0] pressed_raw;
  assign pressed_raw = bus.ui_in[6:0] ~^ {7{btn_level}};

  logic [6:0] sync_q [SYNC_STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 7'd0;
    end else begin
      sync_q[0] <= pressed_raw;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  logic [6:0] btn;
  logic       any_btn;
  assign btn     = sync_q[SYNC_STAGES-1];
  assign any_btn = |btn;

  // Lowest-index pressed button selects the die size
  logic [6:0] die_sel;
  always_comb begin
    die_sel = 7'd0;
    casez (btn)
      7'b??????1: die_sel = 7'd4;
      7'b?????10: die_sel = 7'd6;
      7'b????100: die_sel = 7'd8;
      7'b???1000: die_sel = 7'd10;
      7'b??10000: die_sel = 7'd12;
      7'b?100000: die_sel = 7'd20;
      7'b1000000: die_sel = 7'd100;
      default:    die_sel = 7'd0;
    endcase
  end

  // Roll state machine
  logic [0:0] state;
  logic [6:0] die_n;
  logic [6:0] counter;
  logic [6:0] result;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      die_n   <= 7'd0;
      counter <= 7'd0;
      result  <= 7'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_btn) begin
            state   <= ST_ROLL;
            die_n   <= die_sel;
            counter <= 7'd1;
            result  <= 7'd0;
          end
        end
        default: begin
          if (any_btn) begin
            counter <= (counter == die_n) ? 7'd1 : counter + 7'd1;
          end else begin
            // counter still holds the value from the last pressed cycle
            state  <= ST_IDLE;
            result <= counter;
          end
        end
      endcase
    end
  end

  // Digit multiplexer: MSB of the free-running counter picks the digit
  logic [MUX_BITS:0] mux_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mux_cnt <= '0;
    else        mux_cnt <= mux_cnt + 1'b1;
  end

  logic digit_sel;
  assign digit_sel = mux_cnt[MUX_BITS];

  // Value on display; 0 means blank
  logic [6:0] disp_val;
`ifdef ROLLING_DISPLAY_EN
  assign disp_val = (state == ST_ROLL) ? counter : result;
`else
  assign disp_val = (state == ST_ROLL) ? 7'd0 : result;
`endif

  // 100 wraps to "00" on the two digits
  logic [6:0] tens_v, units_v;
  assign tens_v  = (disp_val == 7'd100) ? 7'd0 : disp_val / 7'd10;
  assign units_v = disp_val % 7'd10;

  logic blank;
  assign blank = (disp_val == 7'd0) || (digit_sel && disp_val < 7'd10);

  logic [6:0] digit_v;
  assign digit_v = digit_sel ? tens_v : units_v;

  logic [6:0] pattern;
  always_comb begin
    pattern = 7'h00;
    if (!blank) begin
      case (digit_v)
        7'd0: pattern = 7'h3F;
        7'd1: pattern = 7'h06;
        7'd2: pattern = 7'h5B;
        7'd3: pattern = 7'h4F;
        7'd4: pattern = 7'h66;
        7'd5: pattern = 7'h6D;
        7'd6: pattern = 7'h7D;
        7'd7: pattern = 7'h07;
        7'd8: pattern = 7'h7F;
        7'd9: pattern = 7'h6F;
        default: pattern = 7'h00;
      endcase
    end
  end

  // dp is never lit; polarity straps act purely combinationally
  assign bus.uo_out  = seg_level ? {1'b0, pattern} : ~{1'b0, pattern};
  assign bus.uio_out = {6'b0,
                        digit_sel  ? com_level : ~com_level,
                        !digit_sel ? com_level : ~com_level};
  assign bus.uio_oe  = 8'b0000_0011;

endmodule

// File: tb/tb_tt_um_dice_roller.sv
// tb/tb_tt_um_dice_roller.sv - self-checking bench for tt_um_dice_roller

module tb_tt_um_dice_roller;
  localparam int MB = 3;
  localparam int SS = 2;
  localparam int PERIOD = 2 ** (MB + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;

  tt_um_dice_roller_if bus ();

  tt_um_dice_roller #(.MUX_BITS(MB), .SYNC_STAGES(SS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'h3F; 1: return 7'h06; 2: return 7'h5B; 3: return 7'h4F;
      4: return 7'h66; 5: return 7'h6D; 6: return 7'h7D; 7: return 7'h07;
      8: return 7'h7F; 9: return 7'h6F; default: return 7'h00;
    endcase
  endfunction

  function automatic int die_of(input logic [6:0] mask);
    int sizes [7] = '{4, 6, 8, 10, 12, 20, 100};
    for (int i = 0; i < 7; i++) if (mask[i]) return sizes[i];
    return 0;
  endfunction

  function automatic logic [7:0] drive_seg(input logic [6:0] p);
    logic [7:0] v;
    v = {1'b0, p};
    return bus.uio_in[6] ? v : ~v;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_straps(input logic b, input logic s, input logic c);
    @(negedge clk);
    bus.uio_in = {c, s, b, 5'b0};
    bus.ui_in  = b ? 8'h00 : 8'h7F;
  endtask

  // Observe a full mux period and compare both digits with value v
  task automatic show(input string tag, input int v);
    logic [6:0] pu, pt;
    logic [1:0] com_u, com_t;
    logic seen_u, seen_t, ok;
    pu = (v == 0) ? 7'h00 : seg_of(v % 10);
    pt = (v < 10) ? 7'h00 : seg_of((v / 10) % 10);
    com_u = {~bus.uio_in[7], bus.uio_in[7]};
    com_t = { bus.uio_in[7], ~bus.uio_in[7]};
    seen_u = 1'b0;
    seen_t = 1'b0;
    for (int i = 0; i < PERIOD; i++) begin
      @(negedge clk);
      ok = (bus.uio_out[1:0] == com_u) || (bus.uio_out[1:0] == com_t);
      chk({tag, ".commons"}, {bus.uio_out[7:2], 1'b0, ok}, 8'h01);
      if (bus.uio_out[1:0] == com_u && !seen_u) begin
        seen_u = 1'b1;
        chk({tag, ".units"}, bus.uo_out, drive_seg(pu));
      end
      if (bus.uio_out[1:0] == com_t && !seen_t) begin
        seen_t = 1'b1;
        chk({tag, ".tens"}, bus.uo_out, drive_seg(pt));
      end
    end
    chk({tag, ".both_phases"}, {6'b0, seen_t, seen_u}, 8'h03);
  endtask

  // Hold mask for k raw cycles (k synchronized cycles) then release
  task automatic roll(input logic [6:0] mask, input int k);
    int first;
    @(negedge clk);
    bus.ui_in = bus.uio_in[5] ? {1'b0, mask} : {1'b0, ~mask};
    first = (k > SS + 2) ? SS + 2 : k;
    repeat (first) @(posedge clk);
`ifndef ROLLING_DISPLAY_EN
    if (k > SS + 2) begin
      @(negedge clk);
      chk("rolling_blank", bus.uo_out, drive_seg(7'h00));
    end
`endif
    repeat (k - first) @(posedge clk);
    @(negedge clk);
    bus.ui_in = bus.uio_in[5] ? 8'h00 : 8'h7F;
    repeat (SS + 3) @(posedge clk);
  endtask

  task automatic roll_chk(input string tag, input logic [6:0] mask, input int k);
    int n;
    n = die_of(mask);
    roll(mask, k);
    show(tag, ((k - 1) % n) + 1);
  endtask

  initial begin
    logic [6:0] m;
    int k;
    bus.ena    = 1'b1;
    bus.uio_in = 8'b1110_0000;
    bus.ui_in  = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset.segs", bus.uo_out, 8'h00);
    chk("reset.commons", bus.uio_out, 8'h01);
    chk("reset.oe", bus.uio_oe, 8'h03);
    @(negedge clk);
    rst_n = 1'b1;
    show("reset.display", 0);

    roll_chk("d6_9", 7'b0000010, 9);
    chk("d6_9.oe", bus.uio_oe, 8'h03);
    roll_chk("d20_15", 7'b0100000, 15);
    set_straps(1'b1, 1'b0, 1'b0);
    show("d20_15.inverted", 5 + 10);
    roll_chk("d20_15_inv", 7'b0100000, 15);
    set_straps(1'b1, 1'b1, 1'b1);
    roll_chk("d100_100", 7'b1000000, 100);
    roll_chk("d100_42", 7'b1000000, 42);

    set_straps(1'b0, 1'b1, 1'b1);
    roll_chk("d4_d12_7", 7'b0010001, 7);

    // Reset in the middle of a roll
    @(negedge clk);
    bus.ui_in = {1'b0, ~7'b0000100};
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    bus.ui_in = 8'h7F;
    repeat (10) @(negedge clk);
    chk("midreset.segs", bus.uo_out, 8'h00);
    chk("midreset.commons", bus.uio_out, 8'h01);
    rst_n = 1'b1;
    repeat (SS + 3) @(posedge clk);
    show("midreset.display", 0);
    roll_chk("d8_after_reset", 7'b0000100, 11);

    // Randomized rolls with random straps
    for (int r = 0; r < 8; r++) begin
      set_straps(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      m = 7'($urandom_range(1, 127));
      k = $urandom_range(1, 130);
      roll_chk($sformatf("rand%0d", r), m, k);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
